// File: rtl/multi_nb.sv
// Radix-2 sequential shift-add multiplier with signed/unsigned mode and a fixed latency.
// One multiplier bit is consumed per cycle; the sign is applied to the magnitude product when the operation ends.
module multi_nb #(
    parameter int LARG_A = 16,
    parameter int LARG_B = 8,
    parameter int LARG_P = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inicio,
    input  logic              com_sinal,
    input  logic [LARG_A-1:0] multiplicando,
    input  logic [LARG_B-1:0] multiplicador,
    output logic [LARG_P-1:0] produto,
    output logic              fim,
    output logic              ocupado,
    output logic              estouro
);

    localparam int LARG_R = LARG_A + LARG_B;
    localparam int LARG_C = $clog2(LARG_B + 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t r_estado;
    estado_t w_prox;

    logic [LARG_R-1:0] r_acc;
    logic [LARG_R-1:0] r_a_desl;
    logic [LARG_B-1:0] r_b;
    logic [LARG_C-1:0] r_cont;
    logic              r_sinal;
    logic              r_com_sinal;
    logic [LARG_P-1:0] r_produto;
    logic              r_fim;
    logic              r_ocupado;
    logic              r_estouro;

    logic              w_aceita;
    logic              w_passo;
    logic              w_final;
    logic [LARG_A-1:0] w_mag_a;
    logic [LARG_B-1:0] w_mag_b;
    logic              w_sinal_novo;
    logic [LARG_R-1:0] w_res;
    logic              w_estouro;

    // Magnitudes are only taken in signed mode; the most negative value wraps to its own unsigned magnitude.
    assign w_mag_a      = (com_sinal && multiplicando[LARG_A-1]) ? -multiplicando : multiplicando;
    assign w_mag_b      = (com_sinal && multiplicador[LARG_B-1]) ? -multiplicador : multiplicador;
    assign w_sinal_novo = com_sinal & (multiplicando[LARG_A-1] ^ multiplicador[LARG_B-1]);

    assign w_res = r_sinal ? -r_acc : r_acc;

    generate
        if (LARG_P == LARG_R) begin : g_sem_corte
            assign w_estouro = 1'b0;
        end else begin : g_corte
            logic w_est_u;
            logic w_est_s;
            assign w_est_u   = |w_res[LARG_R-1:LARG_P];
            // Signed fit: the discarded bits and the new sign bit must all agree.
            assign w_est_s   = ~((&w_res[LARG_R-1:LARG_P-1]) | ~(|w_res[LARG_R-1:LARG_P-1]));
            assign w_estouro = r_com_sinal ? w_est_s : w_est_u;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox   = r_estado;
        w_aceita = 1'b0;
        w_passo  = 1'b0;
        w_final  = 1'b0;
        case (r_estado)
            OCIOSO, FIM: begin
                if (inicio) begin
                    w_aceita = 1'b1;
                    w_prox   = CALCULA;
                end
            end
            CALCULA: begin
                if (r_cont != '0) begin
                    w_passo = 1'b1;
                end else begin
                    w_final = 1'b1;
                    w_prox  = FIM;
                end
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_a_desl    <= '0;
            r_b         <= '0;
            r_cont      <= '0;
            r_sinal     <= 1'b0;
            r_com_sinal <= 1'b0;
            r_produto   <= '0;
            r_estouro   <= 1'b0;
            r_fim       <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            if (w_aceita) begin
                r_acc       <= '0;
                r_a_desl    <= {{LARG_B{1'b0}}, w_mag_a};
                r_b         <= w_mag_b;
                r_cont      <= LARG_C'(LARG_B);
                r_sinal     <= w_sinal_novo;
                r_com_sinal <= com_sinal;
            end else if (w_passo) begin
                if (r_b[0]) begin
                    r_acc <= r_acc + r_a_desl;
                end
                r_a_desl <= r_a_desl << 1;
                r_b      <= r_b >> 1;
                r_cont   <= r_cont - LARG_C'(1);
            end else if (w_final) begin
                r_produto <= w_res[LARG_P-1:0];
                r_estouro <= w_estouro;
            end
            // Flags follow the next state so they change on the same edge as the state.
            r_ocupado <= (w_prox == CALCULA);
            r_fim     <= (w_prox == FIM);
        end
    end

    assign produto = r_produto;
    assign fim     = r_fim;
    assign ocupado = r_ocupado;
    assign estouro = r_estouro;

endmodule
